if_id_buffer: RTL
=================

# if_id_buffer

Fetch-to-decode pipeline buffer of the MIPS-32 core. It accepts `{pc, instr}` pairs from the fetch cycle over a valid/ready handshake and holds them in a small in-order FIFO, so a decode-side stall does not lose fetched words. It also breaks the head instruction into its R/I/J fields, the sign-extended immediate, PC+4 and the jump address for the decode/register-file stage. A flush input discards all buffered work on a taken branch or jump.

## Interface
- `DEPTH`, default 2: FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: fetch presents a valid pair.
- `in_ready`  out  1: buffer can accept this cycle.
- `in_pc`  in  32: byte address of the fetched instruction.
- `in_instr`  in  32: fetched instruction word, big-endian assembled.
- `flush`  in  1: discard all entries and any same-cycle push.
- `out_valid`  out  1: head entry present.
- `out_ready`  in  1: decode consumes the head this cycle.
- `out_pc`, `out_instr`  out  32 each: head entry.
- `opcode`  out  6: `instr[31:26]`.
- `rs`, `rt`, `rd`, `shamt`  out  5 each: `instr[25:21]`, `[20:16]`, `[15:11]`, `[10:6]`.
- `funct`  out  6: `instr[5:0]`.
- `imm_sext`  out  32: `{{16{instr[15]}}, instr[15:0]}`.
- `pc_plus4`  out  32: `out_pc + 4`, modulo 2^32.
- `jaddr`  out  32: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
- `is_nop`  out  1: head instruction is `32'h00000000`.

## Operation
- Storage: circular FIFO of `DEPTH` 64-bit entries, plus read pointer, write pointer and count.
  - Pointers are `log2(DEPTH)` bits and wrap naturally.
  - Count is `log2(DEPTH)+1` bits.
- Push when `in_valid && in_ready && !flush`. Pop when `out_valid && out_ready && !flush`.
- `in_ready = (count != DEPTH)`, driven from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- When full, a pop does not free a slot in the same cycle; `in_ready` rises the following cycle.
- Simultaneous push and pop with `0 < count < DEPTH`: count is unchanged and both pointers advance.
- `out_valid = (count != 0)`.
- All data and decode outputs are forced to 0 when `out_valid` is 0, including `pc_plus4` and `jaddr`. Otherwise they are derived combinationally from the head entry.
- Flush:
  - Next cycle: count = 0, read pointer = write pointer, `out_valid` = 0.
  - A same-cycle push is dropped and a same-cycle pop has no effect.
- Priority: `rst` > `flush` > push/pop.
- Reset, including mid-transfer: count = 0, pointers = 0, storage contents don't-care.
  - After the edge: `out_valid` = 0, `in_ready` = 1, all data and decode outputs = 0.
- Ordering is strictly FIFO. No entry is duplicated or reordered.
- Holding data while `in_ready` is low is fetch's responsibility. The buffer never samples inputs when `in_ready` = 0.

## Timing
- Latency: a pair accepted at edge N appears on `out_*` with `out_valid` = 1 immediately after edge N when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained.
- `out_valid`, `in_ready` and the head entry change only at clock edges.
- Decode outputs settle combinationally within the same cycle as the head entry.
- Flush and reset take effect at the edge where they are sampled high. Outputs reflect the cleared state in the following cycle.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `in_ready` = 1, all `out_*` and decode outputs = 0. The first push after release lands at the head.
- **Decode:** push pc = `32'h00000008`, instr = `32'h2128FFFC` (addi) → next cycle:
  - `opcode` = 8, `rs` = 9, `rt` = 8;
  - `imm_sext` = `32'hFFFFFFFC`, `pc_plus4` = `32'h0000000C`, `is_nop` = 0.
- **Jump:** push pc = `32'h0000000C`, instr = `32'h08000010` → `opcode` = 2, `pc_plus4` = `32'h00000010`, `jaddr` = `32'h00000040`.
- **Backpressure:** hold `out_ready` = 0 and push pcs 0 and 4 → `in_ready` = 0 after the second push, and a third offer is not taken.
  - Raise `out_ready` for one cycle → head advances to pc 4.
  - `in_ready` = 1 the next cycle.
  - Order preserved: 0, 4, then 8.
- **Simultaneous push/pop:** at count = 1, push and pop in the same cycle → count stays 1 and the head becomes the new pair. Continuous streaming of pcs 0, 4, 8, 12 emerges in order, one per cycle.
- **Flush:** with 2 entries, assert `flush` together with `in_valid` (pc `32'h20`) → next cycle `out_valid` = 0, `in_ready` = 1, and pc `32'h20` never appears.
  - Repeat with `rst` and `flush` both high → reset state.

Source files
------------

// File: rtl/if_id_buffer.sv
// Fetch-to-decode buffer: small in-order FIFO of {pc, instr} pairs with the
// head instruction split into MIPS R/I/J fields for the decode stage.
module if_id_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic [31:0] pc_plus4,
  output logic [31:0] jaddr,
  output logic        is_nop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [63:0]   head;
  logic [31:0]   head_pc, head_instr, head_p4;

  // Handshake flags come only from registered count, so out_ready never
  // reaches in_ready combinationally (a pop at full frees a slot next cycle).
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {in_pc, in_instr};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Stale storage is masked so an empty buffer presents all-zero fields.
  always_comb begin
    head       = mem_q[rd_ptr_q];
    head_pc    = out_valid ? head[63:32] : '0;
    head_instr = out_valid ? head[31:0]  : '0;
    head_p4    = head_pc + 32'd4;
    out_pc     = head_pc;
    out_instr  = head_instr;
    opcode     = head_instr[31:26];
    rs         = head_instr[25:21];
    rt         = head_instr[20:16];
    rd         = head_instr[15:11];
    shamt      = head_instr[10:6];
    funct      = head_instr[5:0];
    imm_sext   = {{16{head_instr[15]}}, head_instr[15:0]};
    pc_plus4   = out_valid ? head_p4 : '0;
    jaddr      = out_valid ? {head_p4[31:28], head_instr[25:0], 2'b00} : '0;
    is_nop     = out_valid && (head_instr == '0);
  end
endmodule
